// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared types and constants for the instruction-memory boot loader.
//   state_e         : loader FSM states (CSUM is only reachable when the
//                     IMEM_LOADER_CHECKSUM_EN macro is defined)
//   LEN_BYTES       : number of length-prefix bytes in the stream
//   BYTES_PER_WORD  : stream bytes packed into one memory word
//   len_from_bytes  : assembles the little-endian word count
//   csum_next       : running XOR checksum update
// -----------------------------------------------------------------------------
package imem_loader_pkg;

  typedef enum logic [2:0] {
    LEN0 = 3'd0,
    LEN1 = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_e;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W          = 8 * LEN_BYTES;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);
  localparam int HOLD_W         = 8 * (BYTES_PER_WORD - 1);

  // Word count arrives low byte first.
  function automatic logic [LEN_W-1:0] len_from_bytes(input logic [7:0] lo,
                                                      input logic [7:0] hi);
    return {hi, lo};
  endfunction

  // Checksum is a plain XOR over the data bytes.
  function automatic logic [7:0] csum_next(input logic [7:0] acc,
                                           input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// -----------------------------------------------------------------------------
// imem_word_packer
// Packs a little-endian byte stream into 32-bit words.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (clears partial word)
//   byte_valid  : a byte is consumed this cycle
//   byte_data   : the byte
//   word_valid  : high in the cycle the last byte of a word is consumed
//   word_data   : assembled word, valid together with word_valid
// word_valid/word_data are combinational so the owner can register the write
// on the same edge that accepts the final byte.
// -----------------------------------------------------------------------------
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word_data
);

  localparam logic [BYTE_CNT_W-1:0] LAST_IDX = BYTE_CNT_W'(BYTES_PER_WORD - 1);

  logic [BYTE_CNT_W-1:0] cnt_r;
  logic [HOLD_W-1:0]     hold_r;

  assign word_valid = byte_valid && (cnt_r == LAST_IDX);
  // Earlier bytes sit in hold_r with the first byte at the bottom.
  assign word_data  = {byte_data, hold_r};

  // Byte counter and right-shifting holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= '0;
      hold_r <= '0;
    end else if (byte_valid) begin
      cnt_r  <= cnt_r + 1'b1;
      hold_r <= {byte_data, hold_r[HOLD_W-1:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Boot-time writer for the core's instruction memory. Consumes a stream of
// {N[7:0], N[15:8], N words little-endian [, checksum]} and writes words
// 0..N-1, then releases the core from reset.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing XOR checksum byte).
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   in_valid    : stream byte valid
//   in_data     : stream byte
//   in_ready    : loader accepts a byte (state-only, registered)
//   mem_we      : one-cycle write strobe
//   mem_waddr   : word address
//   mem_wdata   : word data
//   core_rst_n  : core reset, released one cycle after DONE is entered
//   done        : sticky, image loaded
//   error       : sticky, load aborted
// -----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst_n,
  output logic              done,
  output logic              error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e AFTER_DATA = CSUM;
`else
  localparam state_e AFTER_DATA = DONE;
`endif

  localparam logic [LEN_W:0] DEPTH_L = (LEN_W + 1)'(DEPTH);

  state_e             state_r;
  logic [LEN_W-1:0]   len_r;
  logic [LEN_W-1:0]   word_cnt_r;
  logic               in_ready_r;
  logic               mem_we_r;
  logic [ADDR_W-1:0]  mem_waddr_r;
  logic [31:0]        mem_wdata_r;
  logic               core_rst_n_r;
  logic               done_r;
  logic               error_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]         csum_r;
`endif

  logic               xfer_s;
  logic               pack_valid_s;
  logic               word_valid_s;
  logic [31:0]        word_data_s;
  logic [LEN_W-1:0]   len_full_s;
  logic [LEN_W-1:0]   word_cnt_inc_s;

  assign xfer_s         = in_valid && in_ready_r;
  assign pack_valid_s   = xfer_s && (state_r == DATA);
  assign len_full_s     = len_from_bytes(len_r[7:0], in_data);
  assign word_cnt_inc_s = word_cnt_r + LEN_W'(1);

  imem_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (pack_valid_s),
    .byte_data  (in_data),
    .word_valid (word_valid_s),
    .word_data  (word_data_s)
  );

  // Loader FSM, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= LEN0;
      len_r        <= '0;
      word_cnt_r   <= '0;
      in_ready_r   <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_waddr_r  <= '0;
      mem_wdata_r  <= 32'h0000_0000;
      core_rst_n_r <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_r       <= 8'h00;
`endif
    end else begin
      mem_we_r <= 1'b0;
      case (state_r)
        LEN0: begin
          in_ready_r <= 1'b1;
          if (xfer_s) begin
            len_r[7:0] <= in_data;
            state_r    <= LEN1;
          end
        end
        LEN1: begin
          in_ready_r <= 1'b1;
          if (xfer_s) begin
            len_r      <= len_full_s;
            word_cnt_r <= '0;
            // Range check happens before any write, so the address never wraps.
            if ({1'b0, len_full_s} > DEPTH_L) begin
              state_r    <= ERR;
              error_r    <= 1'b1;
              in_ready_r <= 1'b0;
            end else if (len_full_s == '0) begin
              state_r    <= AFTER_DATA;
              done_r     <= (AFTER_DATA == DONE);
              in_ready_r <= (AFTER_DATA != DONE);
            end else begin
              state_r <= DATA;
            end
          end
        end
        DATA: begin
          in_ready_r <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (xfer_s) begin
            csum_r <= csum_next(csum_r, in_data);
          end
`endif
          if (word_valid_s) begin
            mem_we_r    <= 1'b1;
            mem_waddr_r <= word_cnt_r[ADDR_W-1:0];
            mem_wdata_r <= word_data_s;
            word_cnt_r  <= word_cnt_inc_s;
            if (word_cnt_inc_s == len_r) begin
              state_r    <= AFTER_DATA;
              done_r     <= (AFTER_DATA == DONE);
              in_ready_r <= (AFTER_DATA != DONE);
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: begin
          in_ready_r <= 1'b1;
          if (xfer_s) begin
            in_ready_r <= 1'b0;
            if (in_data == csum_r) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= ERR;
              error_r <= 1'b1;
            end
          end
        end
`endif
        DONE: begin
          // Release trails DONE entry by one edge so the last write lands first.
          in_ready_r   <= 1'b0;
          done_r       <= 1'b1;
          core_rst_n_r <= 1'b1;
        end
        ERR: begin
          in_ready_r   <= 1'b0;
          error_r      <= 1'b1;
          core_rst_n_r <= 1'b0;
        end
        default: begin
          // Unreachable encodings abort the load and keep the core in reset.
          state_r      <= ERR;
          in_ready_r   <= 1'b0;
          error_r      <= 1'b1;
          core_rst_n_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_r;
  assign mem_we     = mem_we_r;
  assign mem_waddr  = mem_waddr_r;
  assign mem_wdata  = mem_wdata_r;
  assign core_rst_n = core_rst_n_r;
  assign done       = done_r;
  assign error      = error_r;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Directed self-checking bench for imem_loader. Works with or without the
// IMEM_LOADER_CHECKSUM_EN macro (checksum bytes are appended when defined).
// -----------------------------------------------------------------------------
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        mem_we;
  logic [9:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        core_rst_n;
  logic        done;
  logic        error;

  int errors = 0;
  int checks = 0;

  logic [9:0]  wr_addr [64];
  logic [31:0] wr_data [64];
  int          wr_total = 0;

  // Normal-load image: N=2, 0x00228293, 0x0062E233 (XOR of data bytes = 0x80).
  logic [7:0] img_norm [10] = '{8'h02, 8'h00, 8'h93, 8'h82, 8'h22, 8'h00,
                                8'h33, 8'hE2, 8'h62, 8'h00};
  int         gaps     [10] = '{3, 0, 5, 1, 2, 4, 0, 5, 1, 2};

  imem_loader #(.DEPTH(1024), .ADDR_W(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .core_rst_n (core_rst_n),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Write-port monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (wr_total < 64) begin
        wr_addr[wr_total] = mem_waddr;
        wr_data[wr_total] = mem_wdata;
      end
      wr_total++;
    end
  end

  // Present one byte and hold it until accepted (bounded). Starts and ends at a negedge.
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 20) begin
      errors++;
      $display("FAIL send_timeout: byte %h not accepted, in_ready=%b after %0d cycles", b, in_ready, t);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'hA5;
  endtask

  // Pulse reset for one edge and check the reset values.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (core_rst_n !== 1'b0) begin errors++; $display("FAIL rst_core_rst_n: got %b want 0", core_rst_n); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++;
    if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL rst_flags: done=%b error=%b want 0 0", done, error); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    checks++;
    if (mem_waddr !== 10'd0) begin errors++; $display("FAIL reset_mem_waddr: got %h want 0", mem_waddr); end
    checks++;
    if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    checks++;
    if (core_rst_n !== 1'b0) begin errors++; $display("FAIL reset_core_rst_n: got %b want 0", core_rst_n); end
    checks++;
    if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL reset_flags: done=%b error=%b want 0 0", done, error); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_normal();
    int base;
    do_reset();
    base = wr_total;
    for (int i = 0; i < 10; i++) send_byte(img_norm[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h80);
`endif
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL normal_done: got %b want 1", done); end
    checks++;
    if (core_rst_n !== 1'b0) begin errors++; $display("FAIL normal_core_rst_early: got %b want 0", core_rst_n); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL normal_in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    checks++;
    if (core_rst_n !== 1'b1) begin errors++; $display("FAIL normal_core_rst_release: got %b want 1", core_rst_n); end
    checks++;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL normal_we_idle: got %b want 0", mem_we); end
    checks++;
    if (wr_total - base !== 2) begin errors++; $display("FAIL normal_wr_count: got %0d want 2", wr_total - base); end
    else begin
      checks++;
      if (wr_addr[base] !== 10'd0 || wr_data[base] !== 32'h00228293) begin
        errors++; $display("FAIL normal_wr0: got addr %0d data %h want 0 00228293", wr_addr[base], wr_data[base]);
      end
      checks++;
      if (wr_addr[base+1] !== 10'd1 || wr_data[base+1] !== 32'h0062E233) begin
        errors++; $display("FAIL normal_wr1: got addr %0d data %h want 1 0062e233", wr_addr[base+1], wr_data[base+1]);
      end
    end
  endtask

  task automatic test_empty();
    int base;
    do_reset();
    base = wr_total;
    send_byte(8'h00);
    send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    checks++;
    if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL empty_done: done=%b error=%b want 1 0", done, error); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL empty_in_ready: got %b want 0", in_ready); end
    repeat (3) @(negedge clk);
    checks++;
    if (core_rst_n !== 1'b1) begin errors++; $display("FAIL empty_core_rst_n: got %b want 1", core_rst_n); end
    checks++;
    if (wr_total - base !== 0) begin errors++; $display("FAIL empty_wr_count: got %0d want 0", wr_total - base); end
  endtask

  task automatic test_oversize();
    int base;
    do_reset();
    base = wr_total;
    send_byte(8'h01);
    send_byte(8'h04);
    checks++;
    if (error !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL oversize_error: error=%b done=%b want 1 0", error, done); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL oversize_in_ready: got %b want 0", in_ready); end
    in_valid = 1'b1;
    in_data  = 8'h11;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (core_rst_n !== 1'b0 || error !== 1'b1) begin errors++; $display("FAIL oversize_hold: core_rst_n=%b error=%b want 0 1", core_rst_n, error); end
    checks++;
    if (wr_total - base !== 0) begin errors++; $display("FAIL oversize_wr_count: got %0d want 0", wr_total - base); end
    // N == DEPTH is the largest legal image.
    do_reset();
    send_byte(8'h00);
    send_byte(8'h04);
    checks++;
    if (error !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL depth_exact: error=%b in_ready=%b done=%b want 0 1 0", error, in_ready, done);
    end
  endtask

  task automatic test_gaps();
    int base;
    do_reset();
    base = wr_total;
    for (int i = 0; i < 10; i++) begin
      send_byte(img_norm[i]);
      in_data = 8'hFF;
      repeat (gaps[i]) @(negedge clk);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h80);
`endif
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || core_rst_n !== 1'b1) begin errors++; $display("FAIL gaps_done: done=%b core_rst_n=%b want 1 1", done, core_rst_n); end
    checks++;
    if (wr_total - base !== 2) begin errors++; $display("FAIL gaps_wr_count: got %0d want 2", wr_total - base); end
    else begin
      checks++;
      if (wr_addr[base] !== 10'd0 || wr_data[base] !== 32'h00228293) begin
        errors++; $display("FAIL gaps_wr0: got addr %0d data %h want 0 00228293", wr_addr[base], wr_data[base]);
      end
      checks++;
      if (wr_addr[base+1] !== 10'd1 || wr_data[base+1] !== 32'h0062E233) begin
        errors++; $display("FAIL gaps_wr1: got addr %0d data %h want 1 0062e233", wr_addr[base+1], wr_data[base+1]);
      end
    end
  endtask

  task automatic test_reset_midload();
    int base;
    do_reset();
    base = wr_total;
    for (int i = 0; i < 8; i++) send_byte(img_norm[i]);
    checks++;
    if (wr_total - base !== 1) begin errors++; $display("FAIL midload_pre_count: got %0d want 1", wr_total - base); end
    do_reset();
    base = wr_total;
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hB3);
    send_byte(8'h73);
    send_byte(8'h62);
    send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'hA2);
`endif
    checks++;
    if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL midload_done: done=%b error=%b want 1 0", done, error); end
    @(negedge clk);
    checks++;
    if (wr_total - base !== 1) begin errors++; $display("FAIL midload_wr_count: got %0d want 1", wr_total - base); end
    else begin
      checks++;
      if (wr_addr[base] !== 10'd0 || wr_data[base] !== 32'h006273B3) begin
        errors++; $display("FAIL midload_wr0: got addr %0d data %h want 0 006273b3", wr_addr[base], wr_data[base]);
      end
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int base;
    do_reset();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h33); send_byte(8'hE2); send_byte(8'h62); send_byte(8'h00);
    send_byte(8'hB3);
    checks++;
    if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL csum_good: done=%b error=%b want 1 0", done, error); end
    do_reset();
    base = wr_total;
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h33); send_byte(8'hE2); send_byte(8'h62); send_byte(8'h00);
    send_byte(8'hB2);
    checks++;
    if (error !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL csum_bad: error=%b done=%b want 1 0", error, done); end
    repeat (3) @(negedge clk);
    checks++;
    if (core_rst_n !== 1'b0) begin errors++; $display("FAIL csum_bad_core_rst_n: got %b want 0", core_rst_n); end
    checks++;
    if (wr_total - base !== 1) begin errors++; $display("FAIL csum_bad_wr_count: got %0d want 1", wr_total - base); end
    else begin
      checks++;
      if (wr_addr[base] !== 10'd0 || wr_data[base] !== 32'h0062E233) begin
        errors++; $display("FAIL csum_bad_wr0: got addr %0d data %h want 0 0062e233", wr_addr[base], wr_data[base]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_normal();
    test_empty();
    test_oversize();
    test_gaps();
    test_reset_midload();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Backstop in case a wait is ever left unbounded.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the single-cycle core's 1024×32 instruction memory. Accepts a length-prefixed little-endian byte stream over a valid/ready handshake, packs bytes into 32-bit words, and drives a word-addressed write port starting at word 0. It holds the core in reset until the image is fully written, then releases it. It is the write-side counterpart of the read-only instruction fetch port.

## Interface

- `DEPTH`, 1024: instruction memory depth in words.
- `ADDR_W`, 10: word-address width; `$clog2(DEPTH)`.
- `clk` in 1: single clock; all state is updated on the rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `in_valid` in 1: the byte on `in_data` is valid.
- `in_data` in 8: stream byte.
- `in_ready` out 1: the loader accepts a byte this cycle. A byte transfers when `in_valid && in_ready`.
- `mem_we` out 1: one-cycle write strobe to the instruction memory.
- `mem_waddr` out ADDR_W: word index (byte address >> 2).
- `mem_wdata` out 32: assembled word.
- `core_rst_n` out 1: active-low reset for the core and the instruction-fetch port. It is 0 while loading.
- `done` out 1: image loaded successfully; sticky until `rst`.
- `error` out 1: load aborted; sticky until `rst`.

## Operation

- **Reset values:** `in_ready`=0, `mem_we`=0, `mem_waddr`=0, `mem_wdata`=0, `core_rst_n`=0, `done`=0, `error`=0. The state is LEN0.
- **Stream format:**
  - 2-byte word count N, low byte first.
  - Then N words, 4 bytes each, least-significant byte first: first byte → `wdata[7:0]`.
- **State machine:**
  - **LEN0:** accept a byte → `len[7:0]`, then go to LEN1.
  - **LEN1:** accept a byte → `len[15:8]`, then:
    - N > DEPTH → ERR.
    - N == 0 → CSUM if the checksum is enabled, else DONE.
    - otherwise → DATA.
  - **DATA:** a 2-bit byte counter fills a shift register. On the 4th byte, issue a write and increment the word counter.
    - After word N-1 → CSUM if the checksum is enabled, else DONE.
  - **CSUM:** present only with `IMEM_LOADER_CHECKSUM_EN`. Accept one byte.
    - Match → DONE.
    - Mismatch → ERR.
  - **DONE:** terminal. `done`=1; `core_rst_n` goes to 1 one cycle after entry.
  - **ERR:** terminal. `error`=1; `core_rst_n` stays 0.
- **`in_ready`:** 1 in LEN0, LEN1, DATA and CSUM; 0 in DONE and ERR. `in_ready` is a registered function of the state only; it never depends on `in_valid`.
- **Stalls:** bubbles on `in_valid` stall the FSM with no side effects.
- **Addressing:**
  - Addresses run sequentially from 0 to N-1.
  - `mem_waddr` never wraps, because N ≤ DEPTH is enforced before any write.
  - Words beyond N are not touched.
- **Reset mid-load:**
  - All state returns to LEN0, and any partial word is discarded.
  - Words already written stay in memory.
  - `core_rst_n` is forced to 0.
- **Simultaneous events:** `rst` has priority over any byte transfer in the same cycle.

## Timing

- **Write latency:** the write strobe is registered. When the 4th byte of word k is accepted at edge t, `mem_we`=1, `mem_waddr`=k and `mem_wdata` are valid during the cycle after t. `mem_we` is 0 otherwise.
- **Throughput:** one byte per cycle; a word every 4 cycles at full rate.
- **Release, no checksum:**
  - The FSM enters DONE at the same edge the last byte is accepted, and `done`=1 from that edge.
  - `core_rst_n` rises one edge later. The final write is therefore committed before the core leaves reset.
- **Release, N == 0:** DONE (or CSUM) is entered at the edge that accepts LEN1.
- **ERR:** entered at the edge that accepts the offending byte. `in_ready` is 0 from the next cycle.

## Configuration

- **`IMEM_LOADER_CHECKSUM_EN` defined:**
  - The running XOR of all data bytes (not the length bytes) is kept in an 8-bit register, cleared on `rst`.
  - One trailing checksum byte is expected after the data, including when N == 0 (expected byte 0x00).
  - Mismatch → ERR, with `core_rst_n` held at 0. Memory contents are already written and are not rolled back.
- **Undefined:** no CSUM state and no XOR register. DONE follows the last data byte directly.

## Structure

- **Package `imem_loader_pkg`:**
  - state enum: LEN0, LEN1, DATA, CSUM, DONE, ERR;
  - `LEN_BYTES`=2;
  - `BYTES_PER_WORD`=4.
- **Sub-module `imem_word_packer`:** byte-to-word shift register plus byte counter. It pulses `word_valid` on the 4th byte and clears on `rst`. The top module owns the FSM, the length/word counters and the write-port registers.

## Test plan

- **Normal load:** N=2 (bytes 02 00), words 0x00228293 and 0x0062E233 sent little-endian back-to-back.
  - Expect `mem_we` pulses at addr 0 with 0x00228293, then addr 1 with 0x0062E233.
  - Expect `done`=1 at the last byte edge and `core_rst_n`=1 one cycle later.
- **Empty image:** N=0 (bytes 00 00), no checksum.
  - Expect no `mem_we`, `done`=1 after the 2nd byte, and `in_ready`=0 afterwards.
- **Oversize:** N=1025 (bytes 01 04) with DEPTH=1024.
  - Expect `error`=1, `in_ready`=0, no writes, and `core_rst_n`=0 indefinitely.
- **Stream gaps:** the normal-load image with random `in_valid` gaps of 0–5 cycles.
  - Expect identical write sequence and data; `mem_we` count is exactly 2.
- **Reset mid-load:** assert `rst` after the 2nd byte of word 1, then reload N=1 with word 0x006273B3.
  - Expect a single write of 0x006273B3 at addr 0 and `done`.
- **Checksum (macro on):** N=1, word 0x0062E233 (bytes 33 E2 62 00), checksum byte 0xB3.
  - Expect `done`.
  - With checksum byte 0xB2: expect `error`=1 and `core_rst_n`=0, while the addr 0 write still occurred.
